// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory-controller read-return path: tracking entries,
// returned lines, FSM states and the wrap-safe cycle-count type.
package mem_ctrl_pkg;

  localparam int unsigned MC_DATA_W     = 64;
  localparam int unsigned MC_BURST_LEN  = 8;
  localparam int unsigned MC_PADDR_BITS = 64;
  localparam int unsigned MC_COL_W      = $clog2(MC_BURST_LEN);
  localparam int unsigned MC_LINE_W     = MC_DATA_W * MC_BURST_LEN;
  localparam int unsigned MC_CYCLE_W    = 32;

  typedef logic [MC_CYCLE_W-1:0] cycle_t;

  typedef struct packed {
    logic [MC_PADDR_BITS-1:0] paddr;
    logic [MC_COL_W-1:0]      col;
    cycle_t                   ts;
  } read_track_t;

  typedef struct packed {
    logic [MC_PADDR_BITS-1:0] paddr;
    logic [MC_LINE_W-1:0]     data;
  } resp_line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } rr_state_e;

  // Elapsed cycles since a timestamp; modular so the counter may wrap freely.
  function automatic cycle_t cycle_age(input cycle_t now, input cycle_t ts);
    return now - ts;
  endfunction

endpackage

// File: rtl/rd_line_fifo.sv
// Parametrised ready/valid FIFO with a peek at the entry behind the head.
// Used both as the read-tracking queue and as the response buffer.
module rd_line_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = resp_line_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  entry_t                   push_data,
  output logic                     push_ready,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output entry_t                   pop_data,
  output entry_t                   pop_next_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_fire, pop_fire;

  assign push_ready    = (count_q < CNT_W'(DEPTH));
  assign pop_valid     = (count_q != '0);
  assign pop_data      = mem_q[rd_q];
  assign pop_next_data = mem_q[rd_q + PTR_W'(1)];
  assign count         = count_q;
  assign push_fire     = push_valid && push_ready;
  assign pop_fire      = pop_valid && pop_ready;

  // Simultaneous push and pop are both honoured; the count stays put.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_fire) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_fire) begin
      rd_d = rd_q + PTR_W'(1);
    end
    if (push_fire && !pop_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_fire && !push_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/read_return_engine.sv
// Read-return engine: timestamps issued READs, captures each burst CAS_LATENCY
// cycles later and returns full lines. Define READ_RETURN_REORDER_EN for
// critical-word-first placement; otherwise beats land in linear order.
module read_return_engine
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = MC_DATA_W,
  parameter int unsigned BURST_LEN   = MC_BURST_LEN,
  parameter int unsigned CAS_LATENCY = 22,
  parameter int unsigned PADDR_BITS  = MC_PADDR_BITS,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned RESP_DEPTH  = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           issue_valid_in,
  input  logic [PADDR_BITS-1:0]          issue_paddr_in,
  input  logic [$clog2(BURST_LEN)-1:0]   issue_col_in,
  output logic                           issue_ready_out,
  input  logic [DATA_W-1:0]              dq_in,
  output logic                           resp_valid_out,
  input  logic                           resp_ready_in,
  output logic [PADDR_BITS-1:0]          resp_paddr_out,
  output logic [BURST_LEN*DATA_W-1:0]    resp_data_out,
  output logic                           bursting_out,
  output logic [$clog2(QUEUE_DEPTH):0]   inflight_out,
  output logic                           overlap_err_out
);

  localparam int unsigned BEAT_W  = $clog2(BURST_LEN);
  localparam int unsigned LINE_W  = BURST_LEN * DATA_W;
  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned RCNT_W  = $clog2(RESP_DEPTH) + 1;
  localparam cycle_t      DUE_AGE = cycle_t'(CAS_LATENCY - 1);

  rr_state_e           state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;
  cycle_t              cycle_q, cycle_d;
  logic                err_q, err_d;

  read_track_t         trk_in, trk_head, trk_next;
  resp_line_t          resp_in, resp_head, resp_next;
  logic [CNT_W-1:0]    trk_count;
  logic [RCNT_W-1:0]   resp_count;
  logic                trk_valid, trk_push_ready, resp_push_ready;
  logic                issue_ready_c, trk_push_c, last_beat_c, capturing_c;
  logic [BEAT_W-1:0]   word_c;
  cycle_t              head_age_c, next_age_c;
  logic                unused_ok;

  assign issue_ready_c = (32'(trk_count) < QUEUE_DEPTH) &&
                         (32'(trk_count) + 32'(resp_count) < RESP_DEPTH);
  assign trk_push_c    = issue_valid_in && issue_ready_c;
  assign capturing_c   = (state_q == CAPTURE);
  assign last_beat_c   = capturing_c && (beat_q == BEAT_W'(BURST_LEN - 1));
  assign head_age_c    = cycle_age(cycle_q, trk_head.ts);
  assign next_age_c    = cycle_age(cycle_q, trk_next.ts);

  always_comb begin
    trk_in.paddr  = issue_paddr_in;
    trk_in.col    = issue_col_in;
    trk_in.ts     = cycle_q;
    resp_in.paddr = trk_head.paddr;
    resp_in.data  = line_d;
  end

  rd_line_fifo #(.DEPTH(QUEUE_DEPTH), .entry_t(read_track_t)) u_track_q (
    .clk           (clk_in),
    .rst           (rst_in),
    .push_valid    (trk_push_c),
    .push_data     (trk_in),
    .push_ready    (trk_push_ready),
    .pop_valid     (trk_valid),
    .pop_ready     (last_beat_c),
    .pop_data      (trk_head),
    .pop_next_data (trk_next),
    .count         (trk_count)
  );

  rd_line_fifo #(.DEPTH(RESP_DEPTH), .entry_t(resp_line_t)) u_resp_buf (
    .clk           (clk_in),
    .rst           (rst_in),
    .push_valid    (last_beat_c),
    .push_data     (resp_in),
    .push_ready    (resp_push_ready),
    .pop_valid     (resp_valid_out),
    .pop_ready     (resp_ready_in),
    .pop_data      (resp_head),
    .pop_next_data (resp_next),
    .count         (resp_count)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter CAPTURE one cycle before beat 0 is due.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WAIT: begin
        if (!trk_valid) begin
          state_d = trk_push_c ? WAIT : IDLE;
        end else if (head_age_c >= DUE_AGE) begin
          state_d = CAPTURE;
        end else begin
          state_d = WAIT;
        end
      end
      CAPTURE: begin
        if (last_beat_c) begin
          if ((trk_count >= CNT_W'(2)) && (next_age_c >= DUE_AGE)) begin
            state_d = CAPTURE;
          end else if ((trk_count >= CNT_W'(2)) || trk_push_c) begin
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: beat placement, line assembly and the sticky timing error.
  always_comb begin
    beat_d = '0;
    line_d = line_q;
`ifdef READ_RETURN_REORDER_EN
    word_c = BEAT_W'(trk_head.col) + beat_q;
`else
    word_c = beat_q;
`endif
    if (capturing_c) begin
      beat_d = beat_q + BEAT_W'(1);
      line_d[32'(word_c)*DATA_W +: DATA_W] = dq_in;
    end
    err_d = err_q;
    if (issue_valid_in && !issue_ready_c) begin
      err_d = 1'b1;
    end
    // A second entry falling due before the current burst ends overlaps it.
    if (capturing_c && !last_beat_c && (trk_count >= CNT_W'(2)) &&
        (next_age_c == DUE_AGE)) begin
      err_d = 1'b1;
    end
    cycle_d = cycle_q + cycle_t'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      beat_q  <= '0;
      line_q  <= '0;
      cycle_q <= '0;
      err_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      line_q  <= line_d;
      cycle_q <= cycle_d;
      err_q   <= err_d;
    end
  end

  assign issue_ready_out = issue_ready_c;
  assign resp_paddr_out  = resp_head.paddr;
  assign resp_data_out   = resp_head.data;
  assign bursting_out    = capturing_c;
  assign inflight_out    = trk_count;
  assign overlap_err_out = err_q;

  assign unused_ok = ^{trk_push_ready, resp_push_ready, trk_head.col,
                       trk_next.paddr, trk_next.col, resp_next};

endmodule

// File: tb/tb_read_return_engine.sv
// Scoreboard bench for read_return_engine: expected lines are queued at issue
// time and compared as the engine hands them out.
module tb_read_return_engine;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BURST   = 8;
  localparam int unsigned CAS     = 22;
  localparam int unsigned PADDR_W = 64;
  localparam int unsigned LINE_W  = DATA_W * BURST;

  typedef struct {
    logic [PADDR_W-1:0] paddr;
    logic [LINE_W-1:0]  data;
    bit                 chk;
  } exp_line_t;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                issue_valid_in;
  logic [PADDR_W-1:0]  issue_paddr_in;
  logic [2:0]          issue_col_in;
  logic                issue_ready_out;
  logic [DATA_W-1:0]   dq_in;
  logic                resp_valid_out;
  logic                resp_ready_in;
  logic [PADDR_W-1:0]  resp_paddr_out;
  logic [LINE_W-1:0]   resp_data_out;
  logic                bursting_out;
  logic [4:0]          inflight_out;
  logic                overlap_err_out;

  int                  checks = 0;
  int                  errors = 0;
  int                  cyc = 0;
  int                  dq_origin = 32;
  logic [DATA_W-1:0]   dq_offset = '0;
  bit                  exp_chk = 1'b1;
  exp_line_t           exp_q[$];

  read_return_engine dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .issue_valid_in  (issue_valid_in),
    .issue_paddr_in  (issue_paddr_in),
    .issue_col_in    (issue_col_in),
    .issue_ready_out (issue_ready_out),
    .dq_in           (dq_in),
    .resp_valid_out  (resp_valid_out),
    .resp_ready_in   (resp_ready_in),
    .resp_paddr_out  (resp_paddr_out),
    .resp_data_out   (resp_data_out),
    .bursting_out    (bursting_out),
    .inflight_out    (inflight_out),
    .overlap_err_out (overlap_err_out)
  );

  always #5 clk_in = ~clk_in;

  // Bench-side cycle index: the value the engine's counter holds this cycle.
  always @(posedge clk_in) begin
    if (rst_in) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Advance one cycle; a line handed out at this edge is checked first.
  task automatic tick();
    exp_line_t e;
    if (resp_valid_out === 1'b1 && resp_ready_in === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_line cyc=%0d got paddr=%h exp none", cyc, resp_paddr_out);
      end else begin
        e = exp_q.pop_front();
        if (resp_paddr_out !== e.paddr || (e.chk && resp_data_out !== e.data)) begin
          errors++;
          $display("FAIL sb_line cyc=%0d got paddr=%h data=%h exp paddr=%h data=%h",
                   cyc, resp_paddr_out, resp_data_out, e.paddr, e.data);
        end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
    issue_valid_in = 1'b0;
    dq_in = 64'(cyc - dq_origin) + dq_offset;
  endtask

  task automatic goto(input int n);
    int k = 0;
    while (cyc != n && k < 1000) begin
      tick();
      k++;
    end
    if (cyc != n) begin
      errors++;
      $display("FAIL goto_timeout got cyc=%0d exp %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    rst_in         = 1'b1;
    issue_valid_in = 1'b0;
    issue_paddr_in = '0;
    issue_col_in   = '0;
    resp_ready_in  = 1'b1;
    dq_in          = '0;
    exp_chk        = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    exp_q.delete();
  endtask

  // Drive one issue; when accepted, queue the line the bursts should build.
  task automatic issue(input logic [PADDR_W-1:0] pa, input int col, input bit acc);
    exp_line_t e;
    int w;
    checks++;
    if (issue_ready_out !== acc) begin
      errors++;
      $display("FAIL issue_ready cyc=%0d got %0b exp %0b", cyc, issue_ready_out, acc);
    end
    issue_valid_in = 1'b1;
    issue_paddr_in = pa;
    issue_col_in   = 3'(col);
    if (acc) begin
      e.paddr = pa;
      e.chk   = exp_chk;
      e.data  = '0;
      for (int i = 0; i < int'(BURST); i++) begin
`ifdef READ_RETURN_REORDER_EN
        w = (col + i) % int'(BURST);
`else
        w = i;
`endif
        e.data[w*DATA_W +: DATA_W] = 64'(cyc + int'(CAS) + i - dq_origin) + dq_offset;
      end
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", resp_valid_out); end
    if (bursting_out !== 1'b0) begin errors++; $display("FAIL rst_bursting got %0b exp 0", bursting_out); end
    if (inflight_out !== 5'd0) begin errors++; $display("FAIL rst_inflight got %0d exp 0", inflight_out); end
    if (overlap_err_out !== 1'b0) begin errors++; $display("FAIL rst_overlap got %0b exp 0", overlap_err_out); end
    if (issue_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", issue_ready_out); end
    if (resp_paddr_out !== '0) begin errors++; $display("FAIL rst_paddr got %h exp 0", resp_paddr_out); end
    if (resp_data_out !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", resp_data_out); end
  endtask

  task automatic test_single_col0();
    do_reset();
    dq_origin = 32;
    dq_offset = '0;
    goto(10);
    issue(64'h0000_1000, 0, 1'b1);
    while (cyc <= 45) begin
      checks += 3;
      if (bursting_out !== (cyc >= 32 && cyc <= 39)) begin
        errors++; $display("FAIL single_bursting cyc=%0d got %0b", cyc, bursting_out);
      end
      if (resp_valid_out !== (cyc == 40)) begin
        errors++; $display("FAIL single_valid cyc=%0d got %0b", cyc, resp_valid_out);
      end
      if (inflight_out !== ((cyc <= 39) ? 5'd1 : 5'd0)) begin
        errors++; $display("FAIL single_inflight cyc=%0d got %0d", cyc, inflight_out);
      end
      if (cyc == 40) begin
        for (int k = 0; k < int'(BURST); k++) begin
          checks++;
          if (resp_data_out[k*DATA_W +: DATA_W] !== 64'(k)) begin
            errors++;
            $display("FAIL single_word%0d got %h exp %h", k, resp_data_out[k*DATA_W +: DATA_W], 64'(k));
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_reorder();
    logic [DATA_W-1:0] ew;
    do_reset();
    dq_origin = 32;
    dq_offset = 64'hA0;
    goto(10);
    issue(64'h0000_2040, 5, 1'b1);
    goto(40);
    checks++;
    if (resp_valid_out !== 1'b1) begin errors++; $display("FAIL reorder_valid got %0b exp 1", resp_valid_out); end
    for (int k = 0; k < int'(BURST); k++) begin
`ifdef READ_RETURN_REORDER_EN
      ew = 64'hA0 + 64'((k + 3) % 8);
`else
      ew = 64'hA0 + 64'(k);
`endif
      checks++;
      if (resp_data_out[k*DATA_W +: DATA_W] !== ew) begin
        errors++;
        $display("FAIL reorder_word%0d got %h exp %h", k, resp_data_out[k*DATA_W +: DATA_W], ew);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    dq_origin = 32;
    dq_offset = 64'h100;
    goto(10);
    issue(64'h0000_3000, 0, 1'b1);
    goto(18);
    issue(64'h0000_3040, 3, 1'b1);
    while (cyc <= 55) begin
      checks += 3;
      if (bursting_out !== (cyc >= 32 && cyc <= 47)) begin
        errors++; $display("FAIL b2b_bursting cyc=%0d got %0b", cyc, bursting_out);
      end
      if (resp_valid_out !== (cyc == 40 || cyc == 48)) begin
        errors++; $display("FAIL b2b_valid cyc=%0d got %0b", cyc, resp_valid_out);
      end
      if (overlap_err_out !== 1'b0) begin
        errors++; $display("FAIL b2b_overlap cyc=%0d got %0b exp 0", cyc, overlap_err_out);
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_lines_left got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_overlap();
    do_reset();
    dq_origin = 32;
    dq_offset = 64'h200;
    goto(10);
    issue(64'h0000_4000, 0, 1'b1);
    goto(13);
    exp_chk = 1'b0;
    issue(64'h0000_4040, 0, 1'b1);
    exp_chk = 1'b1;
    while (cyc <= 55) begin
      checks += 3;
      if (overlap_err_out !== (cyc >= 35)) begin
        errors++; $display("FAIL ovl_err cyc=%0d got %0b", cyc, overlap_err_out);
      end
      if (bursting_out !== (cyc >= 32 && cyc <= 47)) begin
        errors++; $display("FAIL ovl_bursting cyc=%0d got %0b", cyc, bursting_out);
      end
      if (resp_valid_out !== (cyc == 40 || cyc == 48)) begin
        errors++; $display("FAIL ovl_valid cyc=%0d got %0b", cyc, resp_valid_out);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int k;
    do_reset();
    dq_origin     = 32;
    dq_offset     = 64'h500;
    resp_ready_in = 1'b0;
    for (int n = 0; n < 4; n++) begin
      goto(10 + 8 * n);
      issue(64'h0000_5000 + 64'(n * 64), n, 1'b1);
    end
    checks += 2;
    if (issue_ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready_drop cyc=%0d got %0b exp 0", cyc, issue_ready_out); end
    if (inflight_out !== 5'd4) begin errors++; $display("FAIL bp_inflight cyc=%0d got %0d exp 4", cyc, inflight_out); end
    goto(42);
    issue(64'h0000_5F00, 0, 1'b0);
    checks++;
    if (overlap_err_out !== 1'b1) begin errors++; $display("FAIL bp_drop_err got %0b exp 1", overlap_err_out); end
    goto(45);
    checks += 2;
    if (resp_valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid45 got %0b exp 1", resp_valid_out); end
    if (resp_paddr_out !== exp_q[0].paddr) begin errors++; $display("FAIL bp_hold45 got %h exp %h", resp_paddr_out, exp_q[0].paddr); end
    goto(70);
    checks += 5;
    if (inflight_out !== 5'd0) begin errors++; $display("FAIL bp_inflight70 got %0d exp 0", inflight_out); end
    if (issue_ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready70 got %0b exp 0", issue_ready_out); end
    if (resp_valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid70 got %0b exp 1", resp_valid_out); end
    if (resp_paddr_out !== exp_q[0].paddr) begin errors++; $display("FAIL bp_hold70 got %h exp %h", resp_paddr_out, exp_q[0].paddr); end
    if (resp_data_out !== exp_q[0].data) begin errors++; $display("FAIL bp_hold_data70 got %h exp %h", resp_data_out, exp_q[0].data); end
    resp_ready_in = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      tick();
      k++;
    end
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain_timeout got %0d left exp 0", exp_q.size()); end
    if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %0b exp 0", resp_valid_out); end
    if (issue_ready_out !== 1'b1) begin errors++; $display("FAIL bp_regrant got %0b exp 1", issue_ready_out); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    dq_origin = 32;
    dq_offset = 64'h700;
    goto(10);
    issue(64'h0000_6000, 0, 1'b1);
    goto(35);
    checks++;
    if (bursting_out !== 1'b1) begin errors++; $display("FAIL mid_bursting35 got %0b exp 1", bursting_out); end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_q.delete();
    checks += 5;
    if (inflight_out !== 5'd0) begin errors++; $display("FAIL mid_inflight got %0d exp 0", inflight_out); end
    if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", resp_valid_out); end
    if (bursting_out !== 1'b0) begin errors++; $display("FAIL mid_bursting got %0b exp 0", bursting_out); end
    if (issue_ready_out !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b exp 1", issue_ready_out); end
    if (overlap_err_out !== 1'b0) begin errors++; $display("FAIL mid_overlap got %0b exp 0", overlap_err_out); end
    for (int n = 0; n < 20; n++) begin
      checks += 2;
      if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL mid_stale_line cyc=%0d got %0b exp 0", cyc, resp_valid_out); end
      if (bursting_out !== 1'b0) begin errors++; $display("FAIL mid_stale_burst cyc=%0d got %0b exp 0", cyc, bursting_out); end
      tick();
    end
  endtask

  initial begin
    rst_in         = 1'b1;
    issue_valid_in = 1'b0;
    issue_paddr_in = '0;
    issue_col_in   = '0;
    resp_ready_in  = 1'b1;
    dq_in          = '0;
    @(negedge clk_in);
    test_reset();
    test_single_col0();
    test_reorder();
    test_back_to_back();
    test_overlap();
    test_backpressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
